// File: rtl/rx_pkg.sv
// Shared types and sizing for the receive-chain channel arbiter and related blocks.
package rx_pkg;
    localparam int CHANNELS         = 8;
    localparam int PARALLEL_SAMPLES = 8;
    localparam int SAMPLE_WIDTH     = 16;
    localparam int DATA_WIDTH       = PARALLEL_SAMPLES * SAMPLE_WIDTH;
    localparam int CHANNEL_ID_WIDTH = $clog2(CHANNELS);

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic {
        IDLE,
        GRANT
    } rx_arb_state_t;
endpackage

// File: rtl/rr_priority_select.sv
// Rotating priority encoder: picks the first set request above last_grant, wrapping.
module rr_priority_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         any
);
    logic [W-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        // Offset N wraps back onto last_grant itself, so it is the lowest priority.
        for (int off = 1; off <= N; off++) begin
            idx = W'((int'(last_grant) + off) % N);
            if (!any && req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rx_channel_arbiter.sv
// Round-robin burst arbiter merging the per-channel receive streams into one
// AXI-Stream output with a single registered output stage.
module rx_channel_arbiter
    import rx_pkg::*;
#(
    parameter int CHANNELS    = rx_pkg::CHANNELS,
    parameter int DATA_WIDTH  = rx_pkg::DATA_WIDTH,
    parameter int BURST_WIDTH = 8,
    parameter int ID_W        = $clog2(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [BURST_WIDTH-1:0]         cfg_burst_len,
    input  logic [CHANNELS-1:0]            cfg_enable,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
    input  logic [CHANNELS-1:0]            s_valid,
    output logic [CHANNELS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_valid,
    output logic                           m_last,
    output logic [ID_W-1:0]                m_channel,
    input  logic                           m_ready,
    output logic                           busy
);
    rx_arb_state_t           state_q, state_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic [BURST_WIDTH-1:0]  len_q, len_d;
    logic [BURST_WIDTH:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [ID_W-1:0]         m_channel_q, m_channel_d;

    logic [CHANNELS-1:0]     req;
    logic [ID_W-1:0]         sel_grant;
    logic                    sel_any;
    logic                    out_free;
    logic                    accept;
    logic                    last_word;
    logic [DATA_WIDTH-1:0]   ch_word [CHANNELS];

    assign req = s_valid & cfg_enable;

    rr_priority_select #(
        .N (CHANNELS),
        .W (ID_W)
    ) u_select (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (sel_grant),
        .any        (sel_any)
    );

    // Ready passes straight through from downstream: the output register can
    // take a new word whenever it is empty or being drained this cycle.
    assign busy      = (state_q == GRANT);
    assign out_free  = !m_valid_q || m_ready;
    assign accept    = busy && out_free && s_valid[grant_q];
    assign last_word = (count_q == {1'b0, len_q});

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign ch_word[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign s_ready[gi] = busy && out_free && (grant_q == ID_W'(gi));
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        count_d      = count_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_channel_d  = m_channel_q;

        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_d      = sel_grant;
                    last_grant_d = sel_grant;
                    len_d        = cfg_burst_len;
                    count_d      = '0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (accept && last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            m_data_d    = ch_word[grant_q];
            m_channel_d = grant_q;
            m_last_d    = last_word;
            m_valid_d   = 1'b1;
            count_d     = count_q + 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(CHANNELS - 1);
            len_q        <= '0;
            count_q      <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_channel_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            count_q      <= count_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_channel_q  <= m_channel_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_channel = m_channel_q;
endmodule

// File: tb/tb_rx_channel_arbiter.sv
// Randomized scoreboard bench for rx_channel_arbiter against a transaction-level model.
module tb_rx_channel_arbiter;
    localparam int NCH = 8;
    localparam int DW  = 128;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [7:0]         cfg_burst_len = '0;
    logic [NCH-1:0]     cfg_enable = '0;
    logic [NCH*DW-1:0]  s_data = '0;
    logic [NCH-1:0]     s_valid = '0;
    logic [NCH-1:0]     s_ready;
    logic [DW-1:0]      m_data;
    logic               m_valid;
    logic               m_last;
    logic [2:0]         m_channel;
    logic               m_ready = 1'b0;
    logic               busy;

    rx_channel_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_burst_len (cfg_burst_len),
        .cfg_enable    (cfg_enable),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_channel     (m_channel),
        .m_ready       (m_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            ch;
        bit            last;
    } exp_t;

    exp_t exp_q[$];
    int   last_chs[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Transaction-level model: which channel owns the output, how many words
    // of its burst remain, and whether the output register holds a word.
    int   seq[NCH];
    bit   mb_busy = 0;
    bit   mb_outv = 0;
    int   mb_grant = 0;
    int   mb_last = NCH - 1;
    int   mb_remain = 0;

    function automatic logic [DW-1:0] mkword(input int c, input int s);
        return {8'(c), 24'(s * 3 + 1), 32'(s), 32'hDEAD_0000 | 32'(c), 32'(~s)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mb_busy   = 0;
        mb_outv   = 0;
        mb_last   = NCH - 1;
        mb_remain = 0;
        exp_q.delete();
    endtask

    task automatic cycle(input logic [7:0] vm, input logic [7:0] en,
                         input logic [7:0] len, input bit mr);
        logic [7:0] exp_rdy;
        logic [7:0] rq;
        bit         acc;
        @(negedge clk);
        s_valid       = vm;
        cfg_enable    = en;
        cfg_burst_len = len;
        m_ready       = mr;
        for (int c = 0; c < NCH; c++) s_data[c*DW +: DW] = mkword(c, seq[c]);
        #2;
        exp_rdy = (mb_busy && (!mb_outv || mr)) ? 8'(1 << mb_grant) : 8'h00;
        chk("s_ready", DW'(s_ready), DW'(exp_rdy));
        chk("busy", DW'(busy), DW'(mb_busy));
        if (!reset_n) begin
            chk("reset_m_valid", DW'(m_valid), '0);
            return;
        end
        acc = mb_busy && vm[mb_grant] && (!mb_outv || mr);
        if (!mb_busy) begin
            rq = vm & en;
            for (int off = 1; off <= NCH; off++) begin
                int c;
                c = (mb_last + off) % NCH;
                if (rq[c]) begin
                    mb_grant  = c;
                    mb_last   = c;
                    mb_remain = int'(len) + 1;
                    mb_busy   = 1;
                    break;
                end
            end
        end else if (acc) begin
            exp_q.push_back('{d: mkword(mb_grant, seq[mb_grant]), ch: mb_grant, last: (mb_remain == 1)});
            seq[mb_grant]++;
            mb_remain--;
            if (mb_remain == 0) mb_busy = 0;
        end
        if (acc) mb_outv = 1;
        else if (mr) mb_outv = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (mb_busy || exp_q.size() != 0); k++)
            cycle(mb_busy ? 8'(1 << mb_grant) : 8'h00, 8'hFF, 8'd7, 1'b1);
        cycle(8'h00, 8'h00, 8'd0, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks that
    // a stalled output word holds still.
    initial begin
        bit            hold_v;
        logic [DW-1:0] hd;
        logic          hl;
        logic [2:0]    hc;
        exp_t          e;
        hold_v = 0;
        hd = '0; hl = 0; hc = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!reset_n) begin
                hold_v = 0;
                continue;
            end
            if (m_valid && hold_v) begin
                chk("hold_data", m_data, hd);
                chk("hold_last", DW'(m_last), DW'(hl));
                chk("hold_chan", DW'(m_channel), DW'(hc));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h with no word expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_channel", DW'(m_channel), DW'(e.ch));
                    chk("m_last", DW'(m_last), DW'(e.last));
                    $display("word ch=%0d last=%0d data=%h", m_channel, m_last, m_data);
                    if (m_last) last_chs.push_back(int'(m_channel));
                end
            end
            hold_v = m_valid && !m_ready;
            hd = m_data;
            hl = m_last;
            hc = m_channel;
        end
    end

    initial begin
        bit reached;
        for (int c = 0; c < NCH; c++) seq[c] = 0;
        model_reset();

        // Reset held with every channel requesting.
        for (int k = 0; k < 3; k++) cycle(8'hFF, 8'hFF, 8'd3, 1'b1);
        cycle(8'h00, 8'hFF, 8'd3, 1'b1);
        reset_n = 1'b1;

        // Fairness: full request set, 4-word bursts.
        last_chs.delete();
        for (int k = 0; k < 50; k++) cycle(8'hFF, 8'hFF, 8'd3, 1'b1);
        if (last_chs.size() < 9) begin
            n_checks++;
            n_fail++;
            $display("FAIL fair_bursts: got %0d bursts expected at least 9", last_chs.size());
        end else begin
            for (int i = 0; i < 9; i++) chk("fair_order", DW'(last_chs[i]), DW'(i % NCH));
        end

        // Masking, with channel 5 disabled part-way through.
        for (int k = 0; k < 25; k++) cycle(8'hFF, 8'hA0, 8'd3, 1'b1);
        for (int k = 0; k < 20; k++) cycle(8'hFF, 8'h80, 8'd3, 1'b1);
        drain();

        // Backpressure: alternating m_ready during 8-word bursts.
        for (int k = 0; k < 30; k++) cycle(8'h01, 8'hFF, 8'd7, (k % 2) == 0);
        drain();

        // Granted source drops valid for five cycles mid-burst.
        for (int k = 0; k < 40; k++)
            cycle((mb_busy && k >= 8 && k < 13) ? ~8'(1 << mb_grant) : 8'hFF, 8'hFF, 8'd7, 1'b1);
        drain();

        // Single-word bursts.
        for (int k = 0; k < 20; k++) cycle(8'($urandom), 8'hFF, 8'd0, 1'b1);
        drain();

        // Random traffic.
        for (int k = 0; k < 400; k++)
            cycle(8'($urandom), 8'($urandom), 8'($urandom_range(0, 5)), 1'($urandom));
        drain();

        // Maximum burst length.
        for (int k = 0; k < 262; k++) cycle(8'h04, 8'h04, 8'd255, 1'b1);
        drain();

        // Asynchronous reset during word 2 of an 8-word burst.
        reached = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(8'hFF, 8'hFF, 8'd7, 1'b1);
            if (mb_busy && mb_remain == 6) begin
                reached = 1;
                break;
            end
        end
        if (!reached) begin
            n_checks++;
            n_fail++;
            $display("FAIL reset_setup: got no burst at word 2 expected one within 20 cycles");
        end
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("async_m_valid", DW'(m_valid), '0);
        chk("async_m_last", DW'(m_last), '0);
        chk("async_s_ready", DW'(s_ready), '0);
        chk("async_busy", DW'(busy), '0);
        model_reset();
        cycle(8'hFF, 8'hFF, 8'd7, 1'b1);
        cycle(8'h00, 8'hFF, 8'd7, 1'b1);
        reset_n = 1'b1;
        last_chs.delete();
        for (int k = 0; k < 12; k++) cycle(8'hFF, 8'hFF, 8'd7, 1'b1);
        if (last_chs.size() < 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL post_reset_burst: got no burst expected channel 0");
        end else begin
            chk("post_reset_chan", DW'(last_chs[0]), '0);
        end
        drain();
        for (int k = 0; k < 4; k++) cycle(8'h00, 8'h00, 8'd0, 1'b1);
        chk("scoreboard_empty", DW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
